// File: rtl/xaui_pkg.sv
// xaui_pkg: shared XAUI code points, PRBS7 seed, align spacing and lane encoder
package xaui_pkg;
    localparam logic [7:0] CODE_I = 8'h07;
    localparam logic [7:0] CODE_T = 8'hFD;
    localparam logic [7:0] CODE_E = 8'hFE;
    localparam logic [7:0] CODE_K = 8'hBC;
    localparam logic [7:0] CODE_R = 8'h1C;
    localparam logic [7:0] CODE_A = 8'h7C;
    localparam logic [7:0] CODE_S = 8'hFB;
    localparam logic [7:0] CODE_Q = 8'h9C;
    localparam logic [6:0] PRBS_SEED = 7'h7F;
    localparam logic [4:0] A_MIN = 5'd16;

    typedef struct packed {
        logic       isk;
        logic [7:0] code;
    } lane_t;

    // Control lanes keep only the codes the transceiver may carry; anything else becomes /E/.
    function automatic lane_t encode_lane(input logic [7:0] d, input logic c);
        lane_t l;
        l.isk  = c;
        l.code = (!c || d == CODE_S || d == CODE_T || d == CODE_E || d == CODE_Q) ? d : CODE_E;
        return l;
    endfunction
endpackage

// File: rtl/xaui_prbs7.sv
// xaui_prbs7: free-running PRBS7 LFSR used to randomise idle K/R choice and ||A|| spacing
//   CLK  in   column clock
//   RST  in   synchronous active-high reset, loads PRBS_SEED
//   o_p  out  current LFSR state
module xaui_prbs7
    import xaui_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    output logic [6:0] o_p
);
    logic [6:0] r_p;

    always_ff @(posedge CLK) begin
        if (RST) r_p <= PRBS_SEED;
        else     r_p <= {r_p[5:0], r_p[6] ^ r_p[5]};
    end

    assign o_p = r_p;
endmodule

// File: rtl/xaui_tx_idle_gen.sv
// xaui_tx_idle_gen: XGMII-to-XAUI transmit idle/align generator with one-cycle latency
//   CLK           in   column clock
//   RST           in   synchronous active-high reset
//   TX_EN         in   0 forces ||K|| on every column
//   XGMII_TXD     in   XGMII column, lane n on [8n+7:8n]
//   XGMII_TXC     in   per-lane control flags
//   TXD           out  encoded column
//   TXCHARISK     out  per-lane K flags
//   ALIGN_STROBE  out  high while an ||A|| column is on TXD
module xaui_tx_idle_gen
    import xaui_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        TX_EN,
    input  logic [31:0] XGMII_TXD,
    input  logic [3:0]  XGMII_TXC,
    output logic [31:0] TXD,
    output logic [3:0]  TXCHARISK,
    output logic        ALIGN_STROBE
);
    logic [6:0]  w_p;
    logic        w_idle;
    logic        w_seen_t;
    logic        w_sel_a;
    lane_t       w_lane;
    logic [31:0] w_lane_txd;
    logic [3:0]  w_lane_isk;
    logic [7:0]  w_idle_code;
    logic [31:0] w_txd;
    logic [3:0]  w_isk;
    logic [4:0]  w_a_next;
    logic [4:0]  r_a_cnt;
    logic        r_force_k;
    logic [31:0] r_txd;
    logic [3:0]  r_isk;
    logic        r_strobe;

    xaui_prbs7 u_prbs (
        .CLK (CLK),
        .RST (RST),
        .o_p (w_p)
    );

    // Lanes after the first /T/ are padded with /K/ so the idle stream starts mid-column.
    always_comb begin
        w_idle     = (XGMII_TXC == 4'hF) && (XGMII_TXD == {4{CODE_I}});
        w_seen_t   = 1'b0;
        w_lane     = '0;
        w_lane_txd = '0;
        w_lane_isk = '0;
        for (int n = 0; n < 4; n++) begin
            w_lane                = encode_lane(XGMII_TXD[8*n +: 8], XGMII_TXC[n]);
            w_lane_txd[8*n +: 8]  = w_seen_t ? CODE_K : w_lane.code;
            w_lane_isk[n]         = w_seen_t | w_lane.isk;
            w_seen_t              = w_seen_t | (XGMII_TXC[n] && XGMII_TXD[8*n +: 8] == CODE_T);
        end
        w_sel_a     = TX_EN && w_idle && r_a_cnt == 5'd0;
        w_idle_code = w_sel_a ? CODE_A : (r_force_k || w_p[0]) ? CODE_K : CODE_R;
        w_txd       = !TX_EN ? {4{CODE_K}} : w_idle ? {4{w_idle_code}} : w_lane_txd;
        w_isk       = (!TX_EN || w_idle) ? 4'hF : w_lane_isk;
        // a_cnt parks at zero until an idle column can carry the ||A||.
        w_a_next    = !TX_EN ? r_a_cnt :
                      w_sel_a ? A_MIN + {1'b0, w_p[3:0]} :
                      (r_a_cnt != 5'd0) ? r_a_cnt - 5'd1 : r_a_cnt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_txd     <= {4{CODE_K}};
            r_isk     <= 4'hF;
            r_strobe  <= 1'b0;
            r_a_cnt   <= A_MIN;
            r_force_k <= 1'b0;
        end else begin
            r_txd     <= w_txd;
            r_isk     <= w_isk;
            r_strobe  <= w_sel_a;
            r_a_cnt   <= w_a_next;
            r_force_k <= TX_EN && !w_idle && w_seen_t;
        end
    end

    assign TXD          = r_txd;
    assign TXCHARISK    = r_isk;
    assign ALIGN_STROBE = r_strobe;
endmodule

// File: tb/tb_xaui_tx_idle_gen.sv
// tb_xaui_tx_idle_gen: directed self-checking bench for xaui_tx_idle_gen
module tb_xaui_tx_idle_gen;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        TX_EN = 1'b0;
    logic [31:0] XGMII_TXD = 32'h07070707;
    logic [3:0]  XGMII_TXC = 4'hF;
    logic [31:0] TXD;
    logic [3:0]  TXCHARISK;
    logic        ALIGN_STROBE;
    int checks = 0;
    int errors = 0;

    localparam logic [31:0] IDLE = 32'h07070707;
    localparam logic [36:0] OUT_K = {1'b0, 4'hF, 32'hBCBCBCBC};
    localparam logic [36:0] OUT_R = {1'b0, 4'hF, 32'h1C1C1C1C};
    localparam logic [36:0] OUT_A = {1'b1, 4'hF, 32'h7C7C7C7C};

    xaui_tx_idle_gen dut (
        .CLK          (CLK),
        .RST          (RST),
        .TX_EN        (TX_EN),
        .XGMII_TXD    (XGMII_TXD),
        .XGMII_TXC    (XGMII_TXC),
        .TXD          (TXD),
        .TXCHARISK    (TXCHARISK),
        .ALIGN_STROBE (ALIGN_STROBE)
    );

    always #5 CLK = ~CLK;

    task automatic step(input logic en, input logic [31:0] d, input logic [3:0] c);
        TX_EN = en;
        XGMII_TXD = d;
        XGMII_TXC = c;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [36:0] exp);
        logic [36:0] obs;
        obs = {ALIGN_STROBE, TXCHARISK, TXD};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_strobe(input string tag, input logic exp);
        checks++;
        assert (ALIGN_STROBE === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, ALIGN_STROBE, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        step(1'b1, IDLE, 4'hF);
        step(1'b1, IDLE, 4'hF);
        chk("reset_state", OUT_K);
        RST = 1'b0;
    endtask

    initial begin
        // Continuous idle after reset: K/R follow p[0], ||A|| at columns 16 and 45.
        do_reset();
        for (int n = 0; n <= 50; n++) begin
            step(1'b1, IDLE, 4'hF);
            chk_strobe("idle_strobe", n == 16 || n == 45);
            if (n == 0)  chk("idle_col0_k", OUT_K);
            if (n == 1)  chk("idle_col1_r", OUT_R);
            if (n == 7)  chk("idle_col7_k", OUT_K);
            if (n == 8)  chk("idle_col8_r", OUT_R);
            if (n == 16) chk("idle_first_a", OUT_A);
            if (n == 19) chk("idle_col19_k", OUT_K);
            if (n == 45) chk("idle_second_a", OUT_A);
        end

        // TX_EN low: solid ||K|| whatever the input, a_cnt frozen at 16.
        do_reset();
        for (int n = 0; n < 100; n++) begin
            step(1'b0, $urandom, 4'($urandom));
            chk("txen0_k", OUT_K);
        end
        for (int n = 0; n <= 16; n++) begin
            step(1'b1, IDLE, 4'hF);
            chk_strobe("txen1_strobe", n == 16);
            if (n == 16) chk("txen1_first_a", OUT_A);
        end

        // Short packet, Q column, bad control column, then reset mid-packet.
        do_reset();
        step(1'b1, 32'h332211FB, 4'b0001);
        chk("pkt_start", {1'b0, 4'b0001, 32'h332211FB});
        step(1'b1, 32'h44556677, 4'b0000);
        chk("pkt_data", {1'b0, 4'b0000, 32'h44556677});
        step(1'b1, 32'h0707FDAA, 4'b1110);
        chk("pkt_term", {1'b0, 4'b1110, 32'hBCBCFDAA});
        step(1'b1, IDLE, 4'hF);
        chk("pkt_forced_k", OUT_K);
        step(1'b1, IDLE, 4'hF);
        chk("pkt_then_r", OUT_R);
        step(1'b1, 32'h0100009C, 4'b0001);
        chk("q_column", {1'b0, 4'b0001, 32'h0100009C});
        step(1'b1, 32'h07075507, 4'hF);
        chk("bad_ctrl_e", {1'b0, 4'hF, 32'hFEFEFEFE});
        step(1'b1, 32'h998877FB, 4'b0001);
        RST = 1'b1;
        step(1'b1, 32'h12345678, 4'b0000);
        chk("mid_pkt_reset", OUT_K);
        RST = 1'b0;

        // 60-column packet spanning a_cnt==0: ||A|| waits for the first idle column.
        step(1'b1, 32'hDDCCBBFB, 4'b0001);
        chk("long_start", {1'b0, 4'b0001, 32'hDDCCBBFB});
        for (int n = 1; n <= 58; n++) begin
            step(1'b1, 32'h01010101 * n, 4'b0000);
            chk_strobe("long_no_a", 1'b0);
            if (n == 20) chk("long_data20", {1'b0, 4'b0000, 32'h14141414});
        end
        step(1'b1, 32'h070707FD, 4'hF);
        chk("long_term", {1'b0, 4'hF, 32'hBCBCBCFD});
        step(1'b1, IDLE, 4'hF);
        chk("long_a_after_t", OUT_A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/xaui_tx_idle_gen.md
# xaui_tx_idle_gen

Transmit-side XAUI idle and alignment generator, sitting between the XGMII transmit path and the four transceiver lanes. It replaces XGMII idle columns with the clause-48 ||K||/||R||/||A|| idle sequence. The pseudo-randomly spaced ||A|| columns are what the far-end receiver's channel-bonding logic uses to deskew the lanes. It also forces a continuous ||K|| stream during link bring-up so the far end can comma-align.

## Interface
- No parameters.
- CLK  in  1  column clock (one XGMII column per cycle).
- RST  in  1  synchronous, active-high reset.
- TX_EN  in  1  0 = force ||K|| on every column; 1 = normal encoding.
- XGMII_TXD  in  32  XGMII column; lane n on bits [8n+7:8n].
- XGMII_TXC  in  4  per-lane control flag.
- TXD  out  32  encoded column to transceivers.
- TXCHARISK  out  4  per-lane K-character flag.
- ALIGN_STROBE  out  1  high in the same cycle an ||A|| column is on TXD.

## Operation
- Codes:
  - /I/ = 0x07, /T/ = 0xFD, /E/ = 0xFE.
  - /K/ = 0xBC, /R/ = 0x1C, /A/ = 0x7C.
  - /S/ = 0xFB, /Q/ = 0x9C.
- PRBS7 state p[6:0]:
  - Reset value 0x7F.
  - Advances every cycle, including when TX_EN=0: p <= {p[5:0], p[6]^p[5]}.
- Align counter a_cnt[4:0]:
  - Reset value 16.
  - Held while TX_EN=0.
  - Otherwise decrements every column while nonzero.
  - Reloaded with 16 + p[3:0] (range 16..31) in the cycle an ||A|| is chosen.
- Column classification, evaluated only when TX_EN=1:
  - Idle column (all TXC=1, all TXD=0x07):
    - a_cnt==0 -> ||A||.
    - Otherwise, if a forced-K flag is set -> ||K||.
    - Otherwise p[0]=1 -> ||K||, p[0]=0 -> ||R||.
  - Column containing /T/ at lane t:
    - Lanes < t and lane t pass through.
    - Lanes > t carry /K/ with CHARISK=1.
    - Sets the forced-K flag for the next column only.
  - Any other column: per-lane passthrough.
    - Data lanes: CHARISK=0.
    - Control lanes (/S/, /T/, /E/, /Q/): CHARISK=1.
    - A control lane holding 0x07 in a non-idle column -> /E/.
    - Any other unrecognised control code -> /E/.
- TX_EN=0: output ||K|| (0xBCBCBCBC, CHARISK=0xF), ALIGN_STROBE=0, forced-K flag cleared.
- ||A|| takes precedence over the forced-K flag.

## Timing
- One-cycle registered latency: the input column at cycle n appears on TXD/TXCHARISK/ALIGN_STROBE at cycle n+1.
- Reset values:
  - TXD = 0xBCBCBCBC.
  - TXCHARISK = 0xF.
  - ALIGN_STROBE = 0.
  - a_cnt = 16, p = 0x7F, forced-K = 0.
- RST mid-packet:
  - Outputs return to reset values on the next edge.
  - The first post-reset column is re-encoded from scratch; no partial state is kept.
- ||A|| spacing: if ||A|| is chosen at column n with reload value L, the next ||A|| occurs no earlier than column n+L+1.
- The next ||A|| is delayed past that point only by non-idle columns occupying the slot where a_cnt==0; a_cnt stays at 0 until an idle column arrives.
- a_cnt reload and the K/R choice both use the current-cycle p, before it advances.

## Structure
- Shared package xaui_pkg holds:
  - Code constants: /I/, /T/, /E/, /K/, /R/, /A/, /S/, /Q/.
  - PRBS7 seed 0x7F.
  - A_MIN = 16.
- One sub-module, xaui_prbs7: free-running 7-bit LFSR with synchronous reset, exposing p[6:0].
- Top level contains:
  - The column classifier, purely combinational.
  - The a_cnt / forced-K state.
  - The output register.

## Test plan
- Reset release, TX_EN=1, continuous idle input:
  - Column 0 output (cycle 1) is ||K|| (p=0x7F).
  - First ||A|| is at input column 16 (p=0x0C), so ALIGN_STROBE pulses at cycle 17.
  - Next ||A|| is at input column 45 (reload 28).
- TX_EN=0 for 100 cycles with arbitrary input:
  - Every output column is 0xBCBCBCBC / 0xF.
  - ALIGN_STROBE never asserts.
  - After TX_EN rises, the first ||A|| appears 16 idle columns later.
- Packet {S,D,D,D} ... {D,T,I,I} followed by idle:
  - The T column outputs lanes 2–3 = 0xBC with CHARISK=0b1110.
  - The following column is ||K|| regardless of p[0].
- Column {0x9C,0x00,0x00,0x01} with TXC=0b0001: passes through unchanged, CHARISK=0b0001.
- Column with TXC=0xF and TXD=0x07070707 except lane 1 = 0x55: lane 1 becomes 0xFE (/E/); the other lanes remain 0x07 and are also replaced with /E/.
- a_cnt reaching 0 during a 60-column packet: no ||A|| inside the packet; ||A|| is emitted on the first idle column after the packet's T column.
